// File: rtl/calc_display_driver.sv
// calc_display_driver
//   Converts the calculator's signed 32-bit result into eight seven-segment
//   digits and scans them onto a common-anode multiplexed display.
//   A sequential double-dabble converter turns the value into signed decimal
//   with leading-zero blanking. A free-running scanner lights one digit at a
//   time for REFRESH_DIV cycles.
//
// Parameters
//   REFRESH_DIV   clock cycles each digit stays lit (>= 2)
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   displayedNum  signed two's-complement value to display
//   seg[6:0]      segment cathodes, active-low, bit0=a .. bit6=g
//   dp            decimal point, active-low, always off
//   an[7:0]       digit anodes, active-low, bit0 = rightmost digit
//   busy          high while a conversion is in flight
module calc_display_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] displayedNum,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FORMAT
    } state_e;

    localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    // Internal digit codes: 0-9 are decimal values, plus two symbols.
    localparam logic [3:0] D_MINUS = 4'hA;
    localparam logic [3:0] D_BLANK = 4'hF;
    // Image of the value 0: digit0 = '0', everything else blank.
    localparam logic [7:0][3:0] ZERO_IMAGE = 32'hFFFF_FFF0;

    // Converter state
    state_e           state_q, state_d;
    logic [31:0]      last_val_q, last_val_d;
    logic             neg_q, neg_d;
    logic [31:0]      mag_q, mag_d;
    logic [39:0]      bcd_q, bcd_d;
    logic [4:0]       iter_q, iter_d;
    logic             busy_q, busy_d;
    logic [7:0][3:0]  digit_q, digit_d;

    // Scanner state
    logic [PW-1:0]    presc_q, presc_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    // Format helpers
    logic [39:0]      bcd_adj;
    logic             ovf;
    int unsigned      msd;
    logic [7:0][3:0]  fmt;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'h40;
            4'd1:    c = 7'h79;
            4'd2:    c = 7'h24;
            4'd3:    c = 7'h30;
            4'd4:    c = 7'h19;
            4'd5:    c = 7'h12;
            4'd6:    c = 7'h02;
            4'd7:    c = 7'h78;
            4'd8:    c = 7'h00;
            4'd9:    c = 7'h10;
            D_MINUS: c = 7'h3F;
            default: c = 7'h7F;
        endcase
        return c;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_val_q <= '0;
            neg_q      <= 1'b0;
            mag_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            busy_q     <= 1'b0;
            digit_q    <= ZERO_IMAGE;
            presc_q    <= '0;
            idx_q      <= '0;
            an_q       <= '1;
            seg_q      <= '1;
        end else begin
            state_q    <= state_d;
            last_val_q <= last_val_d;
            neg_q      <= neg_d;
            mag_q      <= mag_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
            busy_q     <= busy_d;
            digit_q    <= digit_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    // Next-state and converter datapath
    always_comb begin
        state_d    = state_q;
        last_val_d = last_val_q;
        neg_d      = neg_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        busy_d     = busy_q;
        digit_d    = digit_q;

        // Add-3 correction for every BCD nibble >= 5 before the shift.
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end

        // Overflow is read from the BCD result: a non-negative value needs
        // digits 8-9 clear; a negative one also needs digit 7 for the sign.
        ovf = neg_q ? (bcd_q[39:28] != '0) : (bcd_q[39:32] != '0);

        msd = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0)
                msd = i;
        end

        fmt = '1;
        for (int unsigned i = 0; i < 8; i++) begin
            if (ovf)
                fmt[i] = D_MINUS;
            else if (i <= msd)
                fmt[i] = bcd_q[4*i +: 4];
            else if (neg_q && (i == msd + 1))
                fmt[i] = D_MINUS;
            else
                fmt[i] = D_BLANK;
        end

        case (state_q)
            ST_IDLE: begin
                if (displayedNum != last_val_q) begin
                    last_val_d = displayedNum;
                    neg_d      = displayedNum[31];
                    // 32-bit unsigned negate is exact for -2^31 (gives 2^31),
                    // so the 33rd magnitude bit is never needed.
                    mag_d      = displayedNum[31] ? (~displayedNum + 32'd1)
                                                  : displayedNum;
                    bcd_d      = '0;
                    iter_d     = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_d, mag_d} = {bcd_adj[38:0], mag_q, 1'b0};
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'd31)
                    state_d = ST_FORMAT;
            end
            ST_FORMAT: begin
                digit_d = fmt;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scanner and registered display outputs
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 3'd1;
        end else begin
            presc_d = presc_q + PW'(1);
        end
        // an and seg both follow idx_q, so they always switch together.
        an_d  = ~(8'd1 << idx_q);
        seg_d = seg_code(digit_q[idx_q]);
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;
    assign busy = busy_q;

endmodule

// File: tb/tb_calc_display_driver.sv
module tb_calc_display_driver;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] displayedNum;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0][6:0] disp;

    always #5 clk = ~clk;

    calc_display_driver #(.REFRESH_DIV(DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .displayedNum (displayedNum),
        .seg          (seg),
        .dp           (dp),
        .an           (an),
        .busy         (busy)
    );

    // Record, for each anode position, the last segment pattern seen there.
    task automatic capture(input int unsigned n);
        for (int d = 0; d < 8; d++) disp[d] = 'x;
        repeat (n) begin
            @(negedge clk);
            for (int d = 0; d < 8; d++)
                if (an == ~(8'd1 << d)) disp[d] = seg;
        end
    endtask

    // Apply a value, count busy-high samples until it drops, then capture.
    task automatic convert(input logic [31:0] val, output int unsigned blen,
                           output bit tmo);
        blen = 0;
        tmo  = 1'b1;
        @(negedge clk);
        displayedNum = val;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) blen++;
            else if (blen > 0) begin
                tmo = 1'b0;
                break;
            end
        end
        if (!tmo) capture(40);
    endtask

    task automatic test_reset();
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        rst = 1'b1;
        displayedNum = 32'd0;
        repeat (3) @(negedge clk);
        checks++; if (an !== 8'hFF) begin failures++; $display("FAIL reset_an: got %h want FF", an); end
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg: got %h want 7F", seg); end
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp: got %b want 1", dp); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            exp_an  = ~(8'd1 << ((k / 4) % 8));
            exp_seg = (((k / 4) % 8) == 0) ? 7'h40 : 7'h7F;
            checks++; if (an !== exp_an) begin failures++; $display("FAIL scan_an k=%0d: got %h want %h", k, an, exp_an); end
            checks++; if (seg !== exp_seg) begin failures++; $display("FAIL scan_seg k=%0d: got %h want %h", k, seg, exp_seg); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL scan_busy k=%0d: got %b want 0", k, busy); end
            checks++; if (dp !== 1'b1) begin failures++; $display("FAIL scan_dp k=%0d: got %b want 1", k, dp); end
        end
    endtask

    task automatic test_conversions();
        logic [31:0]     vals [7];
        logic [7:0][6:0] imgs [7];
        string           names [7];
        int unsigned     blen;
        bit              tmo;
        vals[0] = 32'd1234;      names[0] = "pos_1234";
        imgs[0] = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19};
        vals[1] = -32'sd42;      names[1] = "neg_42";
        imgs[1] = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h19, 7'h24};
        vals[2] = -32'sd9999999; names[2] = "neg_9999999";
        imgs[2] = {7'h3F, {7{7'h10}}};
        vals[3] = 32'd100000000; names[3] = "ovf_pos";
        imgs[3] = {8{7'h3F}};
        vals[4] = -32'sd10000000; names[4] = "ovf_neg";
        imgs[4] = {8{7'h3F}};
        vals[5] = 32'h8000_0000; names[5] = "ovf_min_int";
        imgs[5] = {8{7'h3F}};
        vals[6] = 32'd99999999;  names[6] = "pos_max";
        imgs[6] = {8{7'h10}};
        for (int t = 0; t < 7; t++) begin
            convert(vals[t], blen, tmo);
            checks++;
            if (tmo) begin
                failures++; $display("FAIL %s timeout: busy never completed", names[t]);
            end else begin
                if (blen != 33) begin failures++; $display("FAIL %s busy_len: got %0d want 33", names[t], blen); end
                for (int d = 0; d < 8; d++) begin
                    checks++;
                    if (disp[d] !== imgs[t][d]) begin
                        failures++;
                        $display("FAIL %s digit%0d: got %h want %h", names[t], d, disp[d], imgs[t][d]);
                    end
                end
            end
        end
    endtask

    task automatic test_mid_change();
        logic [7:0][6:0] img5, img7;
        int unsigned blen;
        bit          done;
        img5 = {{7{7'h7F}}, 7'h12};
        img7 = {{7{7'h7F}}, 7'h78};
        blen = 0;
        done = 1'b0;
        @(negedge clk);
        displayedNum = 32'd5;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) begin
                blen++;
                if (blen == 10) displayedNum = 32'd7;
            end else if (blen > 0) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            failures++; $display("FAIL mid_first timeout: busy never completed");
        end else if (blen != 33) begin
            failures++; $display("FAIL mid_first busy_len: got %0d want 33", blen);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_rebusy: got %b want 1", busy); end
        capture(32);
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (disp[d] !== img5[d]) begin failures++; $display("FAIL mid_show5 digit%0d: got %h want %h", d, disp[d], img5[d]); end
        end
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin done = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!done) begin failures++; $display("FAIL mid_second timeout: busy stuck high"); end
        capture(40);
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (disp[d] !== img7[d]) begin failures++; $display("FAIL mid_show7 digit%0d: got %h want %h", d, disp[d], img7[d]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0][6:0] img;
        int unsigned blen;
        bit          done;
        img = {{5{7'h7F}}, 7'h00, 7'h00, 7'h00};
        @(negedge clk);
        displayedNum = 32'd888;
        done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) begin done = 1'b1; break; end
        end
        checks++; if (!done) begin failures++; $display("FAIL rmid_start: busy got %b want 1", busy); end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy_rst: got %b want 0", busy); end
        checks++; if (an !== 8'hFF) begin failures++; $display("FAIL rmid_an_rst: got %h want FF", an); end
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL rmid_seg_rst: got %h want 7F", seg); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_reconv: busy got %b want 1", busy); end
        checks++; if (an !== 8'hFE) begin failures++; $display("FAIL rmid_an: got %h want FE", an); end
        checks++; if (seg !== 7'h40) begin failures++; $display("FAIL rmid_zero_image: got %h want 40", seg); end
        blen = busy ? 1 : 0;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) blen++;
            else begin done = 1'b1; break; end
        end
        checks++;
        if (!done) begin
            failures++; $display("FAIL rmid_done timeout: busy stuck high");
        end else if (blen != 33) begin
            failures++; $display("FAIL rmid_busy_len: got %0d want 33", blen);
        end
        capture(40);
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (disp[d] !== img[d]) begin failures++; $display("FAIL rmid_888 digit%0d: got %h want %h", d, disp[d], img[d]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        displayedNum = 32'd0;
        test_reset();
        test_conversions();
        test_mid_change();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
